instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the control/instruction decoder. Accepts instruction fields (class, registers, funct3, immediate) over a valid/ready handshake.
- Encodes each accepted instruction into a 32-bit RV32I word in the shared opcode map: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, B 1100011, JAL 1101111, JALR 1100111.
- Writes the words sequentially into instruction memory, so test programs are loaded into the 5-stage pipeline without hand-assembled hex files.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 64, maximum number of words written before the block reports full; legal range 1..1024.

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  field bundle valid.
- in_ready_o  output  1  block can accept a bundle this cycle.
- op_i  input  3  class: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal.
- alt_i  input  1  R-type funct7 = 0100000 when 1 (SUB/SRA), else 0000000.
- funct3_i  input  3  funct3 for R, I-ALU and BRANCH; ignored for the other classes.
- rd_i, rs1_i, rs2_i  input  5 each  register indices.
- imm_i  input  21  signed immediate, already sign-extended; its width covers the JAL range.
- clear_i  input  1  restart the write pointer at BASE_ADDR.
- mem_we_o  output  1  instruction-memory write strobe.
- mem_addr_o  output  32  byte address of the write.
- mem_data_o  output  32  encoded instruction.
- count_o  output  11  number of words written since reset or clear.
- full_o  output  1  count_o == DEPTH.
- err_o  output  1  one-cycle pulse when an illegal bundle is accepted.

Behaviour:
- Reset values: state IDLE, in_ready_o = 1, mem_we_o = 0, mem_addr_o = BASE_ADDR, mem_data_o = 0, count_o = 0, full_o = 0, err_o = 0.
- Handshake: a bundle is accepted when in_valid_i & in_ready_o at a rising edge. in_ready_o is 1 only in IDLE.

FSM states and transitions:
- IDLE, legal op accepted: register the encoded word and mem_addr_o = BASE_ADDR + 4*count_o, then go to WRITE.
- IDLE, op 7 accepted: err_o = 1 for the next cycle only, no write, count unchanged, stay in IDLE.
- WRITE: mem_we_o = 1 for exactly one cycle, count_o increments. Next state is FULL if the new count equals DEPTH, else IDLE.
- FULL: in_ready_o = 0 and full_o = 1. Left only by rst_i or clear_i.
- Latency: accept edge to mem_we_o high is 1 cycle. Sustained throughput is 1 word per 2 cycles.

Encodings (imm = imm_i):
- R: {alt?7'b0100000:7'b0, rs2, rs1, funct3, rd, 0110011}.
- I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}.
- LW: {imm[11:0], rs1, 010, rd, 0000011}.
- JALR: {imm[11:0], rs1, 000, rd, 1100111}.
- SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
- BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}. imm[0] is ignored.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}. imm[0] is ignored.
- Immediate bits above a format's range are dropped without error.

Boundary conditions:
- clear_i (any state, rst_i low): count_o = 0 and mem_addr_o = BASE_ADDR, state goes to IDLE, mem_we_o = 0. A write pending in WRITE is aborted, and a bundle presented in the same cycle is not accepted.
- rst_i dominates clear_i and in_valid_i. Reset during WRITE suppresses the strobe.
- in_valid_i while not ready: the bundle must be held stable by the source and is not sampled.
- DEPTH = 1: first write goes directly to FULL.
- Address arithmetic is 32-bit wrap-around; it is not checked against memory size.

Test Plan:
- Reset, then ADDI x1,x0,5 (op 1, f3 0, rd 1, imm 5) -> one cycle later mem_we_o = 1, addr 0x0, data 0x00500093; count_o = 1.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 with in_valid_i held high -> in_ready_o toggles 1/0. Writes 0x002081B3 @0x0 and 0x402081B3 @0x4.
- Encode coverage:
  - SW x2,8(x1) -> 0x0020A423.
  - BEQ x1,x2,+8 -> 0x00208463.
  - JAL x1,+16 -> 0x010000EF.
  - Immediate sign extension: ADDI x1,x0,-1 -> 0xFFF00093.
- Illegal op 7 between two ADDIs -> err_o pulses 1 cycle, no mem_we_o. Second ADDI is written at 0x4, count_o = 2.
- DEPTH = 4, five bundles offered -> four writes (0x0..0xC), full_o = 1, in_ready_o stays 0. clear_i then restores ready, and the next write lands at 0x0.
- Assert rst_i in the WRITE cycle -> no mem_we_o, all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction field bundles into 32-bit words and streams them
// into instruction memory at consecutive word addresses starting at BASE_ADDR.
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  op_i,
    input  logic        alt_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [20:0] imm_i,
    input  logic        clear_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [10:0] count_o,
    output logic        full_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [10:0] DepthCount = 11'(DEPTH);

    state_t      state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] encodedWord;
    logic        opLegal;
    logic [10:0] countNext;

    always_comb begin
        encodedWord = 32'h0000_0000;
        opLegal     = 1'b1;
        case (op_i)
            3'd0: encodedWord = {(alt_i ? 7'b0100000 : 7'b0000000), rs2_i, rs1_i,
                                 funct3_i, rd_i, 7'b0110011};
            3'd1: encodedWord = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0010011};
            3'd2: encodedWord = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
            3'd3: encodedWord = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
            3'd4: encodedWord = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                 imm_i[4:1], imm_i[11], 7'b1100011};
            3'd5: encodedWord = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                 rd_i, 7'b1101111};
            3'd6: encodedWord = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
            default: opLegal = 1'b0;
        endcase
    end

    // clear_i overrides everything but reset; it also blocks acceptance in its cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = 1'b0;
        countNext = count_q + 11'd1;
        if (clear_i) begin
            state_d = IDLE;
            count_d = 11'd0;
            addr_d  = BASE_ADDR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (opLegal) begin
                            data_d  = encodedWord;
                            addr_d  = BASE_ADDR + {19'd0, count_q, 2'b00};
                            state_d = WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    count_d = countNext;
                    state_d = (countNext == DepthCount) ? FULL : IDLE;
                end
                FULL: state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= 11'd0;
            addr_q  <= BASE_ADDR;
            data_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // The strobe is gated so a reset or clear arriving in WRITE aborts the write.
    assign mem_we_o   = (state_q == WRITE) && !rst_i && !clear_i;
    assign in_ready_o = (state_q == IDLE) && !clear_i;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign count_o    = count_q;
    assign full_o     = (state_q == FULL);
    assign err_o      = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encodings and handshake
// corner cases, then randomized bundles checked against a field-packing model.
module tb_instr_encoder_loader;

    localparam logic [31:0] BaseAddr = 32'h0000_0000;
    localparam int          Depth    = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  op_i;
    logic        alt_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [20:0] imm_i;
    logic        clear_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [10:0] count_o;
    logic        full_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int mCount = 0;

    instr_encoder_loader #(
        .BASE_ADDR (BaseAddr),
        .DEPTH     (Depth)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_i       (op_i),
        .alt_i      (alt_i),
        .funct3_i   (funct3_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .clear_i    (clear_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference encoder: places each field at its bit position with shifts and masks.
    function automatic logic [31:0] refEncode(input logic [2:0] op, input logic alt,
                                              input logic [2:0] f3, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [20:0] imm);
        logic [31:0] ix, d, s1, s2, f;
        ix = {{11{imm[20]}}, imm};
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        f  = 32'(f3) << 12;
        case (op)
            3'd0: return (alt ? 32'h4000_0000 : 32'h0) | s2 | s1 | f | d | 32'h33;
            3'd1: return ((ix & 32'hFFF) << 20) | s1 | f | d | 32'h13;
            3'd2: return ((ix & 32'hFFF) << 20) | s1 | (32'd2 << 12) | d | 32'h03;
            3'd3: return (((ix >> 5) & 32'h7F) << 25) | s2 | s1 | (32'd2 << 12)
                         | ((ix & 32'h1F) << 7) | 32'h23;
            3'd4: return (((ix >> 12) & 32'h1) << 31) | (((ix >> 5) & 32'h3F) << 25)
                         | s2 | s1 | f | (((ix >> 1) & 32'hF) << 8)
                         | (((ix >> 11) & 32'h1) << 7) | 32'h63;
            3'd5: return (((ix >> 20) & 32'h1) << 31) | (((ix >> 1) & 32'h3FF) << 21)
                         | (((ix >> 11) & 32'h1) << 20) | (((ix >> 12) & 32'hFF) << 12)
                         | d | 32'h6F;
            3'd6: return ((ix & 32'hFFF) << 20) | s1 | d | 32'h67;
            default: return 32'h0;
        endcase
    endfunction

    task automatic driveFields(input logic [2:0] op, input logic alt, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [20:0] imm);
        op_i = op; alt_i = alt; funct3_i = f3;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'd1);
        checkOutput({tag, "_we"},    32'(mem_we_o),   32'd0);
        checkOutput({tag, "_addr"},  mem_addr_o,      BaseAddr);
        checkOutput({tag, "_data"},  mem_data_o,      32'd0);
        checkOutput({tag, "_count"}, 32'(count_o),    32'd0);
        checkOutput({tag, "_full"},  32'(full_o),     32'd0);
        checkOutput({tag, "_err"},   32'(err_o),      32'd0);
    endtask

    // Inputs are driven and outputs sampled around the falling edge.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic alt,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [20:0] imm, input logic [31:0] expWord);
        driveFields(op, alt, f3, rd, rs1, rs2, imm);
        in_valid_i = 1'b1;
        #1;
        checkOutput({tag, "_ready_before"}, 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        if (op == 3'd7) begin
            checkOutput({tag, "_err"},   32'(err_o),    32'd1);
            checkOutput({tag, "_we"},    32'(mem_we_o), 32'd0);
            checkOutput({tag, "_count"}, 32'(count_o),  32'(mCount));
            @(negedge clk_i);
            #1;
            checkOutput({tag, "_err_end"}, 32'(err_o), 32'd0);
        end else begin
            checkOutput({tag, "_we"},    32'(mem_we_o),   32'd1);
            checkOutput({tag, "_addr"},  mem_addr_o,      BaseAddr + 32'(4 * mCount));
            checkOutput({tag, "_data"},  mem_data_o,      expWord);
            checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'd0);
            mCount++;
            @(negedge clk_i);
            #1;
            checkOutput({tag, "_we_end"}, 32'(mem_we_o),   32'd0);
            checkOutput({tag, "_count"},  32'(count_o),    32'(mCount));
            checkOutput({tag, "_full"},   32'(full_o),     32'(mCount == Depth));
            checkOutput({tag, "_ready_after"}, 32'(in_ready_o), 32'(mCount != Depth));
        end
    endtask

    task automatic clearPulse(input string tag, input logic validDuring);
        clear_i    = 1'b1;
        in_valid_i = validDuring;
        #1;
        checkOutput({tag, "_ready_in_clear"}, 32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        mCount = 0;
        checkOutput({tag, "_count"}, 32'(count_o),    32'd0);
        checkOutput({tag, "_addr"},  mem_addr_o,      BaseAddr);
        checkOutput({tag, "_we"},    32'(mem_we_o),   32'd0);
        checkOutput({tag, "_full"},  32'(full_o),     32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'd1);
    endtask

    task automatic resetPulse();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        mCount = 0;
    endtask

    // Holds a bundle on the inputs while full and confirms nothing is taken.
    task automatic offerWhileFull(input string tag);
        driveFields(3'd1, 1'b0, 3'd0, 5'd7, 5'd7, 5'd0, 21'd1);
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput({tag, "_ready"}, 32'(in_ready_o), 32'd0);
            checkOutput({tag, "_we"},    32'(mem_we_o),   32'd0);
            checkOutput({tag, "_full"},  32'(full_o),     32'd1);
            checkOutput({tag, "_count"}, 32'(count_o),    32'(Depth));
            @(negedge clk_i);
        end
    endtask

    initial begin
        logic [2:0]  rOp;
        logic        rAlt;
        logic [2:0]  rF3;
        logic [4:0]  rRd, rRs1, rRs2;
        logic [20:0] rImm;

        rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0;
        driveFields(3'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 21'd0);
        @(negedge clk_i);
        resetPulse();
        checkResetState("reset");

        applyStimulus("addi5", 3'd1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd5, 32'h0050_0093);

        // Back-to-back ADD then SUB with valid held high the whole time.
        resetPulse();
        driveFields(3'd0, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        in_valid_i = 1'b1;
        #1;
        checkOutput("b2b_ready0", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        #1;
        checkOutput("b2b_add_we",    32'(mem_we_o),   32'd1);
        checkOutput("b2b_add_data",  mem_data_o,      32'h0020_81B3);
        checkOutput("b2b_add_addr",  mem_addr_o,      32'h0000_0000);
        checkOutput("b2b_ready1",    32'(in_ready_o), 32'd0);
        alt_i = 1'b1;
        @(negedge clk_i);
        #1;
        checkOutput("b2b_ready2", 32'(in_ready_o), 32'd1);
        checkOutput("b2b_we_gap", 32'(mem_we_o),   32'd0);
        checkOutput("b2b_count1", 32'(count_o),    32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        checkOutput("b2b_sub_we",   32'(mem_we_o),   32'd1);
        checkOutput("b2b_sub_data", mem_data_o,      32'h4020_81B3);
        checkOutput("b2b_sub_addr", mem_addr_o,      32'h0000_0004);
        checkOutput("b2b_ready3",   32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        #1;
        checkOutput("b2b_count2", 32'(count_o), 32'd2);
        mCount = 2;

        clearPulse("clr1", 1'b0);
        applyStimulus("sw",     3'd3, 1'b0, 3'd0, 5'd0, 5'd1, 5'd2, 21'd8,        32'h0020_A423);
        applyStimulus("beq",    3'd4, 1'b0, 3'd0, 5'd0, 5'd1, 5'd2, 21'd8,        32'h0020_8463);
        applyStimulus("jal",    3'd5, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd16,       32'h0100_00EF);
        applyStimulus("addim1", 3'd1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'h1F_FFFF,  32'hFFF0_0093);
        offerWhileFull("full1");

        // Illegal class between two ADDIs.
        clearPulse("clr2", 1'b1);
        applyStimulus("ill_a", 3'd1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd5, 32'h0050_0093);
        applyStimulus("ill_x", 3'd7, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd5, 32'h0);
        applyStimulus("ill_b", 3'd1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd5, 32'h0050_0093);
        checkOutput("ill_count", 32'(count_o), 32'd2);

        // Fill to depth, offer a fifth, then clear with valid held and refill.
        clearPulse("clr3", 1'b0);
        for (int i = 0; i < Depth; i++)
            applyStimulus("fill", 3'd1, 1'b0, 3'd0, 5'(i + 1), 5'd0, 5'd0, 21'(i),
                          refEncode(3'd1, 1'b0, 3'd0, 5'(i + 1), 5'd0, 5'd0, 21'(i)));
        offerWhileFull("full2");
        clearPulse("clr4", 1'b1);
        applyStimulus("refill", 3'd1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 21'd5, 32'h0050_0093);

        // Reset asserted during the WRITE cycle must kill the strobe.
        driveFields(3'd0, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 21'd0);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checkOutput("rstw_we", 32'(mem_we_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        mCount = 0;
        checkResetState("rstw");

        // Randomized bundles against the reference encoder.
        for (int n = 0; n < 200; n++) begin
            if (mCount == Depth) begin
                if ($urandom_range(0, 1) == 0) offerWhileFull("rnd_full");
                clearPulse("rnd_clr", 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 15) == 0) begin
                clearPulse("rnd_clr_mid", 1'($urandom_range(0, 1)));
            end
            rOp  = 3'($urandom_range(0, 7));
            rAlt = 1'($urandom());
            rF3  = 3'($urandom());
            rRd  = 5'($urandom());
            rRs1 = 5'($urandom());
            rRs2 = 5'($urandom());
            rImm = 21'($urandom());
            applyStimulus("rnd", rOp, rAlt, rF3, rRd, rRs1, rRs2, rImm,
                          refEncode(rOp, rAlt, rF3, rRd, rRs1, rRs2, rImm));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
